// File: rtl/brush_writer_if.sv
// Command handshake and pixel RAM write bus for the brush writer.
interface brush_writer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [7:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [2:0]  cmd_color;
    logic [1:0]  cmd_size;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [2:0]  wr_data;
    logic        done;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, cmd_size,
        input  cmd_ready, wr_en, wr_addr, wr_data, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, cmd_size,
        output cmd_ready, wr_en, wr_addr, wr_data, done
    );
endinterface

// File: rtl/brush_writer.sv
// Brush writer: paints a (2r+1)^2 square around a point, or clears the whole
// canvas, emitting one pixel RAM write slot per cycle.
// Both commands walk a rectangle row-major; PAINT clips slots that fall off
// the canvas (slot still consumed), CLEAR's rectangle is the canvas itself.
module brush_writer #(
    parameter int       MAX_COORDINATE = 128,
    parameter logic [2:0] ERASE_COLOR  = 3'b000
) (
    input  logic         clk,
    input  logic         reset,
    brush_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_e;

    // 10-bit signed coordinates: x-r reaches -3, x+r reaches 258.
    localparam logic signed [9:0] MAX_S  = 10'(MAX_COORDINATE);
    localparam logic signed [9:0] LAST_S = MAX_S - 10'sd1;

    state_e             state_q, state_d;
    logic signed [9:0]  px_q, px_d, py_q, py_d;
    logic signed [9:0]  x_lo_q, x_lo_d, x_hi_q, x_hi_d, y_hi_q, y_hi_d;
    logic [2:0]         color_q, color_d;
    logic               wr_en_q, wr_en_d;
    logic [14:0]        wr_addr_q, wr_addr_d;
    logic [2:0]         wr_data_q, wr_data_d;
    logic               done_q, done_d;

    logic               emit_go;
    logic signed [9:0]  emit_x, emit_y;
    logic signed [9:0]  cx, cy, rr;

    assign cx = signed'({2'b00, bus.cmd_x});
    assign cy = signed'({2'b00, bus.cmd_y});
    assign rr = signed'({8'b0, bus.cmd_size});

    function automatic logic in_range(input logic signed [9:0] x, input logic signed [9:0] y);
        return (x >= 10'sd0) && (x < MAX_S) && (y >= 10'sd0) && (y < MAX_S);
    endfunction

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.done      = done_q;

    // Next-state: accept, walk the rectangle, and stage the next write slot.
    always_comb begin
        state_d   = state_q;
        px_d      = px_q;
        py_d      = py_q;
        x_lo_d    = x_lo_q;
        x_hi_d    = x_hi_q;
        y_hi_d    = y_hi_q;
        color_d   = color_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        emit_go   = 1'b0;
        emit_x    = px_q;
        emit_y    = py_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    emit_go = 1'b1;
                    if (bus.cmd_op) begin
                        state_d = CLEAR;
                        x_lo_d  = 10'sd0;
                        x_hi_d  = LAST_S;
                        y_hi_d  = LAST_S;
                        emit_x  = 10'sd0;
                        emit_y  = 10'sd0;
                        color_d = ERASE_COLOR;
                    end else begin
                        state_d = PAINT;
                        x_lo_d  = cx - rr;
                        x_hi_d  = cx + rr;
                        y_hi_d  = cy + rr;
                        emit_x  = cx - rr;
                        emit_y  = cy - rr;
                        color_d = bus.cmd_color;
                    end
                end
            end
            PAINT, CLEAR: begin
                if (px_q == x_hi_q && py_q == y_hi_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    emit_go = 1'b1;
                    if (px_q == x_hi_q) begin
                        emit_x = x_lo_q;
                        emit_y = py_q + 10'sd1;
                    end else begin
                        emit_x = px_q + 10'sd1;
                        emit_y = py_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit_go) begin
            px_d = emit_x;
            py_d = emit_y;
            if (in_range(emit_x, emit_y)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = {emit_y[6:0], emit_x[7:0]};
                wr_data_d = color_d;
            end
        end
    end

    // State and registered write-bus outputs; reset aborts any command.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            px_q      <= '0;
            py_q      <= '0;
            x_lo_q    <= '0;
            x_hi_q    <= '0;
            y_hi_q    <= '0;
            color_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            px_q      <= px_d;
            py_q      <= py_d;
            x_lo_q    <= x_lo_d;
            x_hi_q    <= x_hi_d;
            y_hi_q    <= y_hi_d;
            color_q   <= color_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end
endmodule
